ex_stage: RTL and testbench

Execute stage of the 64-bit RISC-V pipeline. It consumes the ID/EX pipeline-register outputs and forwards operands from EX/MEM and MEM/WB. It computes the ALU or iterative-multiply result and registers it, with the downstream controls, into its internal EX/MEM register. While a multiply is in flight it raises `stall_out` to freeze PC, IF/ID and ID/EX.

---
 rtl/ex_stage_pkg.sv | 108 ++++++++++
 rtl/ex_stage_mul_iter64.sv | 90 +++++++++
 rtl/ex_stage.sv | 204 ++++++++++++++++++++
 tb/tb_ex_stage.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_stage_pkg.sv
// -----------------------------------------------------------------------------
// ex_pkg: shared types and constants for the execute stage.
//   alu_op_e    : resolved ALU operation after Aluop/funct decode
//   fwd_sel_e   : operand forwarding source
//   mul_state_e : iterative multiplier FSM states
//   ALUOP_*     : Aluop class encodings from the ID stage
//   F3_*        : funct3 encodings for the integer ALU table
// Helper functions: fwd_select (forwarding priority), decode_alu_op.
// -----------------------------------------------------------------------------
package ex_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE = 2'b11;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9,
        ALU_MUL  = 4'd10
    } alu_op_e;

    typedef enum logic [1:0] {
        FWD_ID    = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_e;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_e;

    // EX/MEM wins over MEM/WB; x0 is never forwarded.
    function automatic fwd_sel_e fwd_select(
        input logic       exmem_we,
        input logic [4:0] exmem_rd,
        input logic       memwb_we,
        input logic [4:0] memwb_rd,
        input logic [4:0] src
    );
        fwd_sel_e sel;
        if (exmem_we && (exmem_rd != 5'd0) && (exmem_rd == src)) begin
            sel = FWD_EXMEM;
        end else if (memwb_we && (memwb_rd != 5'd0) && (memwb_rd == src)) begin
            sel = FWD_MEMWB;
        end else begin
            sel = FWD_ID;
        end
        return sel;
    endfunction

    // funct7_0 only selects the M-extension for R-type; for I-type that bit
    // is part of the immediate (RV64 shamt[5]) and must be ignored.
    // Any funct7_0=1 R-type maps to ALU_MUL, whose combinational ALU value is
    // 0, so unsupported M ops yield 0.
    function automatic alu_op_e decode_alu_op(
        input logic [1:0] aluop,
        input logic [2:0] f3,
        input logic       f7_5,
        input logic       f7_0
    );
        alu_op_e op;
        op = ALU_ADD;
        case (aluop)
            ALUOP_ADD: op = ALU_ADD;
            ALUOP_SUB: op = ALU_SUB;
            ALUOP_RTYPE, ALUOP_ITYPE: begin
                if ((aluop == ALUOP_RTYPE) && f7_0) begin
                    op = ALU_MUL;
                end else begin
                    case (f3)
                        F3_ADD:  op = ((aluop == ALUOP_RTYPE) && f7_5) ? ALU_SUB : ALU_ADD;
                        F3_SLL:  op = ALU_SLL;
                        F3_SLT:  op = ALU_SLT;
                        F3_SLTU: op = ALU_SLTU;
                        F3_XOR:  op = ALU_XOR;
                        F3_SR:   op = f7_5 ? ALU_SRA : ALU_SRL;
                        F3_OR:   op = ALU_OR;
                        F3_AND:  op = ALU_AND;
                        default: op = ALU_ADD;
                    endcase
                end
            end
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/ex_stage_mul_iter64.sv
// -----------------------------------------------------------------------------
// mul_iter64: iterative shift-add multiplier, one partial product per cycle.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           latch a/b and begin (honoured only in IDLE)
//   abort           return to IDLE immediately (higher priority than start)
//   a, b            operands (XLEN)
//   busy            high in BUSY
//   done            high for the single DONE cycle; product is valid then
//   product         low XLEN bits of a*b
// -----------------------------------------------------------------------------
module mul_iter64
    import ex_pkg::*;
#(
    parameter int XLEN       = 64,
    parameter int MUL_CYCLES = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] product
);

    localparam int             CW    = $clog2(MUL_CYCLES);
    localparam logic [CW-1:0]  LAST  = CW'(MUL_CYCLES - 1);
    localparam logic [CW-1:0]  ONE   = CW'(1);

    mul_state_e      r_state;
    logic [CW-1:0]   r_count;
    logic [XLEN-1:0] r_mcand;
    logic [XLEN-1:0] r_mplier;
    logic [XLEN-1:0] r_acc;
    logic [XLEN-1:0] w_addend;

    assign w_addend = r_mplier[0] ? r_mcand : {XLEN{1'b0}};

    // FSM, iteration counter and shift-add datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= MUL_IDLE;
            r_count  <= {CW{1'b0}};
            r_mcand  <= {XLEN{1'b0}};
            r_mplier <= {XLEN{1'b0}};
            r_acc    <= {XLEN{1'b0}};
        end else if (abort) begin
            r_state <= MUL_IDLE;
            r_count <= {CW{1'b0}};
            r_acc   <= {XLEN{1'b0}};
        end else begin
            case (r_state)
                MUL_IDLE: begin
                    if (start) begin
                        r_mcand  <= a;
                        r_mplier <= b;
                        r_acc    <= {XLEN{1'b0}};
                        r_count  <= {CW{1'b0}};
                        r_state  <= MUL_BUSY;
                    end else begin
                        r_state  <= MUL_IDLE;
                    end
                end
                MUL_BUSY: begin
                    r_acc    <= r_acc + w_addend;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    if (r_count == LAST) begin
                        r_count <= {CW{1'b0}};
                        r_state <= MUL_DONE;
                    end else begin
                        r_count <= r_count + ONE;
                    end
                end
                // DONE always falls back to IDLE so a held MUL cannot retrigger
                // in the same cycle the result is taken.
                MUL_DONE: r_state <= MUL_IDLE;
                default:  r_state <= MUL_IDLE;
            endcase
        end
    end

    assign busy    = (r_state == MUL_BUSY);
    assign done    = (r_state == MUL_DONE);
    assign product = r_acc;

endmodule

// File: rtl/ex_stage.sv
// -----------------------------------------------------------------------------
// ex_stage: execute stage of the 64-bit RISC-V pipeline.
// Consumes ID/EX outputs, forwards operands from EX/MEM (own register) and
// MEM/WB, computes the ALU or iterative MUL result and registers it with the
// downstream controls into the internal EX/MEM register.
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   flush_in                         bubble into EX/MEM, abort multiply
//   AluSrc/MemtoReg/RegWrite/MemRead/MemWrite_in, Aluop_in, funct3_in,
//   funct7_5_in, funct7_0_in         ID/EX controls and decode bits
//   rs1Data_in, rs2Data_in, immediate_in, rs_in, rt_in, rd_in  ID/EX data
//   memwb_RegWrite_in, memwb_rd_in, memwb_wdata_in             MEM/WB bypass
//   MemtoReg/RegWrite/MemRead/MemWrite_out, alu_result_out,
//   store_data_out, zero_out, rd_out EX/MEM register outputs
//   stall_out                        combinational hold for PC, IF/ID, ID/EX
// -----------------------------------------------------------------------------
module ex_stage
    import ex_pkg::*;
#(
    parameter int XLEN       = 64,
    parameter int MUL_CYCLES = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_in,
    input  logic            AluSrc_in,
    input  logic            MemtoReg_in,
    input  logic            RegWrite_in,
    input  logic            MemRead_in,
    input  logic            MemWrite_in,
    input  logic [1:0]      Aluop_in,
    input  logic [2:0]      funct3_in,
    input  logic            funct7_5_in,
    input  logic            funct7_0_in,
    input  logic [XLEN-1:0] rs1Data_in,
    input  logic [XLEN-1:0] rs2Data_in,
    input  logic [XLEN-1:0] immediate_in,
    input  logic [4:0]      rs_in,
    input  logic [4:0]      rt_in,
    input  logic [4:0]      rd_in,
    input  logic            memwb_RegWrite_in,
    input  logic [4:0]      memwb_rd_in,
    input  logic [XLEN-1:0] memwb_wdata_in,
    output logic            MemtoReg_out,
    output logic            RegWrite_out,
    output logic            MemRead_out,
    output logic            MemWrite_out,
    output logic [XLEN-1:0] alu_result_out,
    output logic [XLEN-1:0] store_data_out,
    output logic            zero_out,
    output logic [4:0]      rd_out,
    output logic            stall_out
);

    // EX/MEM register
    logic            r_memtoreg;
    logic            r_regwrite;
    logic            r_memread;
    logic            r_memwrite;
    logic [XLEN-1:0] r_alu_result;
    logic [XLEN-1:0] r_store_data;
    logic            r_zero;
    logic [4:0]      r_rd;

    fwd_sel_e        w_sel_a;
    fwd_sel_e        w_sel_b;
    logic [XLEN-1:0] w_fwd_a;
    logic [XLEN-1:0] w_fwd_b;
    logic [XLEN-1:0] w_op_b;
    logic [5:0]      w_shamt;
    alu_op_e         w_alu_op;
    logic [XLEN-1:0] w_alu_result;
    logic            w_mul_present;
    logic            w_mul_idle;
    logic            w_mul_start;
    logic            w_mul_busy;
    logic            w_mul_done;
    logic [XLEN-1:0] w_mul_product;
    logic            w_stall;

    assign w_sel_a = fwd_select(r_regwrite, r_rd, memwb_RegWrite_in, memwb_rd_in, rs_in);
    assign w_sel_b = fwd_select(r_regwrite, r_rd, memwb_RegWrite_in, memwb_rd_in, rt_in);

    // Operand A bypass mux.
    always_comb begin
        w_fwd_a = rs1Data_in;
        case (w_sel_a)
            FWD_EXMEM: w_fwd_a = r_alu_result;
            FWD_MEMWB: w_fwd_a = memwb_wdata_in;
            FWD_ID:    w_fwd_a = rs1Data_in;
            default:   w_fwd_a = rs1Data_in;
        endcase
    end

    // Operand B bypass mux (also the store data).
    always_comb begin
        w_fwd_b = rs2Data_in;
        case (w_sel_b)
            FWD_EXMEM: w_fwd_b = r_alu_result;
            FWD_MEMWB: w_fwd_b = memwb_wdata_in;
            FWD_ID:    w_fwd_b = rs2Data_in;
            default:   w_fwd_b = rs2Data_in;
        endcase
    end

    assign w_op_b   = AluSrc_in ? immediate_in : w_fwd_b;
    assign w_shamt  = w_op_b[5:0];
    assign w_alu_op = decode_alu_op(Aluop_in, funct3_in, funct7_5_in, funct7_0_in);

    // Single-cycle integer ALU; MUL class contributes 0 here.
    always_comb begin
        w_alu_result = {XLEN{1'b0}};
        case (w_alu_op)
            ALU_ADD:  w_alu_result = w_fwd_a + w_op_b;
            ALU_SUB:  w_alu_result = w_fwd_a - w_op_b;
            ALU_SLL:  w_alu_result = w_fwd_a << w_shamt;
            ALU_SLT:  w_alu_result = {{(XLEN-1){1'b0}}, ($signed(w_fwd_a) < $signed(w_op_b))};
            ALU_SLTU: w_alu_result = {{(XLEN-1){1'b0}}, (w_fwd_a < w_op_b)};
            ALU_XOR:  w_alu_result = w_fwd_a ^ w_op_b;
            ALU_SRL:  w_alu_result = w_fwd_a >> w_shamt;
            ALU_SRA:  w_alu_result = $unsigned($signed(w_fwd_a) >>> w_shamt);
            ALU_OR:   w_alu_result = w_fwd_a | w_op_b;
            ALU_AND:  w_alu_result = w_fwd_a & w_op_b;
            ALU_MUL:  w_alu_result = {XLEN{1'b0}};
            default:  w_alu_result = {XLEN{1'b0}};
        endcase
    end

    assign w_mul_present = (Aluop_in == ALUOP_RTYPE) && funct7_0_in &&
                           (funct3_in == F3_ADD) && RegWrite_in;
    assign w_mul_idle    = !w_mul_busy && !w_mul_done;
    assign w_mul_start   = w_mul_idle && w_mul_present && !flush_in;

    // Flush overrides even BUSY so the upstream stages release the same cycle;
    // reset forces every output low.
    assign w_stall   = !rst && !flush_in && ((w_mul_idle && w_mul_present) || w_mul_busy);
    assign stall_out = w_stall;

    mul_iter64 #(
        .XLEN       (XLEN),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (w_mul_start),
        .abort   (flush_in),
        .a       (w_fwd_a),
        .b       (w_fwd_b),
        .busy    (w_mul_busy),
        .done    (w_mul_done),
        .product (w_mul_product)
    );

    // EX/MEM register: bubble on flush/stall, product on DONE, else ALU result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_memtoreg   <= 1'b0;
            r_regwrite   <= 1'b0;
            r_memread    <= 1'b0;
            r_memwrite   <= 1'b0;
            r_alu_result <= {XLEN{1'b0}};
            r_store_data <= {XLEN{1'b0}};
            r_zero       <= 1'b0;
            r_rd         <= 5'd0;
        end else if (flush_in || w_stall) begin
            r_memtoreg   <= 1'b0;
            r_regwrite   <= 1'b0;
            r_memread    <= 1'b0;
            r_memwrite   <= 1'b0;
            r_alu_result <= {XLEN{1'b0}};
            r_store_data <= {XLEN{1'b0}};
            r_zero       <= 1'b0;
            r_rd         <= 5'd0;
        end else if (w_mul_done) begin
            r_memtoreg   <= MemtoReg_in;
            r_regwrite   <= RegWrite_in;
            r_memread    <= MemRead_in;
            r_memwrite   <= MemWrite_in;
            r_alu_result <= w_mul_product;
            r_store_data <= w_fwd_b;
            r_zero       <= (w_mul_product == {XLEN{1'b0}});
            r_rd         <= rd_in;
        end else begin
            r_memtoreg   <= MemtoReg_in;
            r_regwrite   <= RegWrite_in;
            r_memread    <= MemRead_in;
            r_memwrite   <= MemWrite_in;
            r_alu_result <= w_alu_result;
            r_store_data <= w_fwd_b;
            r_zero       <= (w_alu_result == {XLEN{1'b0}});
            r_rd         <= rd_in;
        end
    end

    assign MemtoReg_out   = r_memtoreg;
    assign RegWrite_out   = r_regwrite;
    assign MemRead_out    = r_memread;
    assign MemWrite_out   = r_memwrite;
    assign alu_result_out = r_alu_result;
    assign store_data_out = r_store_data;
    assign zero_out       = r_zero;
    assign rd_out         = r_rd;

endmodule

// File: tb/tb_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_ex_stage: scoreboard bench for ex_stage. Expected EX/MEM contents are
// pushed when an instruction is driven and popped when the stage delivers.
// -----------------------------------------------------------------------------
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_in;
    logic        AluSrc_in, MemtoReg_in, RegWrite_in, MemRead_in, MemWrite_in;
    logic [1:0]  Aluop_in;
    logic [2:0]  funct3_in;
    logic        funct7_5_in, funct7_0_in;
    logic [63:0] rs1Data_in, rs2Data_in, immediate_in;
    logic [4:0]  rs_in, rt_in, rd_in;
    logic        memwb_RegWrite_in;
    logic [4:0]  memwb_rd_in;
    logic [63:0] memwb_wdata_in;
    logic        MemtoReg_out, RegWrite_out, MemRead_out, MemWrite_out;
    logic [63:0] alu_result_out, store_data_out;
    logic        zero_out;
    logic [4:0]  rd_out;
    logic        stall_out;

    always #5 clk = ~clk;

    ex_stage #(.XLEN(64), .MUL_CYCLES(64)) dut (
        .clk(clk), .rst(rst), .flush_in(flush_in),
        .AluSrc_in(AluSrc_in), .MemtoReg_in(MemtoReg_in), .RegWrite_in(RegWrite_in),
        .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in), .Aluop_in(Aluop_in),
        .funct3_in(funct3_in), .funct7_5_in(funct7_5_in), .funct7_0_in(funct7_0_in),
        .rs1Data_in(rs1Data_in), .rs2Data_in(rs2Data_in), .immediate_in(immediate_in),
        .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in),
        .memwb_RegWrite_in(memwb_RegWrite_in), .memwb_rd_in(memwb_rd_in),
        .memwb_wdata_in(memwb_wdata_in),
        .MemtoReg_out(MemtoReg_out), .RegWrite_out(RegWrite_out),
        .MemRead_out(MemRead_out), .MemWrite_out(MemWrite_out),
        .alu_result_out(alu_result_out), .store_data_out(store_data_out),
        .zero_out(zero_out), .rd_out(rd_out), .stall_out(stall_out)
    );

    // {MemtoReg, RegWrite, MemRead, MemWrite, rd, zero, result, store}
    logic [137:0] obs_vec;
    assign obs_vec = {MemtoReg_out, RegWrite_out, MemRead_out, MemWrite_out,
                      rd_out, zero_out, alu_result_out, store_data_out};

    typedef struct packed {
        logic [1:0]  aluop;
        logic [2:0]  f3;
        logic        f75;
        logic        f70;
        logic        alusrc;
        logic [3:0]  ctl;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        mw_we;
        logic [4:0]  mw_rd;
        logic [63:0] mw_data;
        logic [63:0] exp_res;
        logic [63:0] exp_sd;
    } op_t;

    int n_checks = 0;
    int n_fail   = 0;
    logic [137:0] sb[$];
    logic [137:0] exp_v;

    function automatic logic [137:0] mk_exp(input logic [3:0] ctl, input logic [4:0] rd,
                                            input logic [63:0] res, input logic [63:0] sd);
        return {ctl, rd, (res == 64'd0), res, sd};
    endfunction

    function automatic op_t mk_op(input logic [1:0] aluop, input logic [2:0] f3,
                                  input logic f75, input logic f70, input logic alusrc,
                                  input logic [3:0] ctl, input logic [63:0] a,
                                  input logic [63:0] b, input logic [63:0] imm,
                                  input logic [4:0] rs, input logic [4:0] rt,
                                  input logic [4:0] rd, input logic mw_we,
                                  input logic [4:0] mw_rd, input logic [63:0] mw_data,
                                  input logic [63:0] exp_res, input logic [63:0] exp_sd);
        op_t o;
        o.aluop = aluop; o.f3 = f3; o.f75 = f75; o.f70 = f70; o.alusrc = alusrc;
        o.ctl = ctl; o.a = a; o.b = b; o.imm = imm; o.rs = rs; o.rt = rt; o.rd = rd;
        o.mw_we = mw_we; o.mw_rd = mw_rd; o.mw_data = mw_data;
        o.exp_res = exp_res; o.exp_sd = exp_sd;
        return o;
    endfunction

    task automatic apply_op(input op_t o);
        Aluop_in = o.aluop; funct3_in = o.f3; funct7_5_in = o.f75; funct7_0_in = o.f70;
        AluSrc_in = o.alusrc;
        {MemtoReg_in, RegWrite_in, MemRead_in, MemWrite_in} = o.ctl;
        rs1Data_in = o.a; rs2Data_in = o.b; immediate_in = o.imm;
        rs_in = o.rs; rt_in = o.rt; rd_in = o.rd;
        memwb_RegWrite_in = o.mw_we; memwb_rd_in = o.mw_rd; memwb_wdata_in = o.mw_data;
    endtask

    task automatic drive_nop();
        apply_op(mk_op(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 4'b0000, 64'd0, 64'd0, 64'd0,
                       5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 64'd0, 64'd0, 64'd0));
        flush_in = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_nop();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (obs_vec !== 138'd0) begin
            n_fail++; $display("FAIL reset_outputs: got %h expected 0", obs_vec);
        end
        // A MUL on the inputs must not raise stall while in reset.
        apply_op(mk_op(2'b10, 3'b000, 1'b0, 1'b1, 1'b0, 4'b0100, 64'd2, 64'd3, 64'd0,
                       5'd1, 5'd2, 5'd3, 1'b0, 5'd0, 64'd0, 64'd6, 64'd3));
        #1;
        n_checks++;
        if (stall_out !== 1'b0) begin
            n_fail++; $display("FAIL reset_stall: got %b expected 0", stall_out);
        end
        drive_nop();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_alu();
        op_t ops[$];
        ops.push_back(mk_op(2'b10, 3'b000, 1'b0, 1'b0, 1'b0, 4'b0100, 64'd5, 64'd7, 64'd0,
                            5'd1, 5'd2, 5'd3, 1'b0, 5'd0, 64'd0, 64'd12, 64'd7));
        ops.push_back(mk_op(2'b10, 3'b000, 1'b1, 1'b0, 1'b0, 4'b0100, 64'd10, 64'd3, 64'd0,
                            5'd1, 5'd2, 5'd5, 1'b0, 5'd0, 64'd0, 64'd7, 64'd3));
        ops.push_back(mk_op(2'b01, 3'b000, 1'b0, 1'b0, 1'b0, 4'b0100, 64'd5, 64'd5, 64'd0,
                            5'd1, 5'd2, 5'd5, 1'b0, 5'd0, 64'd0, 64'd0, 64'd5));
        ops.push_back(mk_op(2'b11, 3'b000, 1'b1, 1'b0, 1'b1, 4'b0100, 64'd10, 64'd99, 64'd5,
                            5'd1, 5'd2, 5'd5, 1'b0, 5'd0, 64'd0, 64'd15, 64'd99));
        ops.push_back(mk_op(2'b10, 3'b010, 1'b0, 1'b0, 1'b0, 4'b0100, 64'hFFFF_FFFF_FFFF_FFFF,
                            64'd1, 64'd0, 5'd1, 5'd2, 5'd5, 1'b0, 5'd0, 64'd0, 64'd1, 64'd1));
        ops.push_back(mk_op(2'b10, 3'b011, 1'b0, 1'b0, 1'b0, 4'b0100, 64'hFFFF_FFFF_FFFF_FFFF,
                            64'd1, 64'd0, 5'd1, 5'd2, 5'd5, 1'b0, 5'd0, 64'd0, 64'd0, 64'd1));
        ops.push_back(mk_op(2'b10, 3'b001, 1'b0, 1'b0, 1'b0, 4'b0100, 64'd1, 64'd65, 64'd0,
                            5'd1, 5'd2, 5'd5, 1'b0, 5'd0, 64'd0, 64'd2, 64'd65));
        ops.push_back(mk_op(2'b10, 3'b100, 1'b0, 1'b0, 1'b0, 4'b0100, 64'hF0, 64'hFF, 64'd0,
                            5'd1, 5'd2, 5'd5, 1'b0, 5'd0, 64'd0, 64'h0F, 64'hFF));
        ops.push_back(mk_op(2'b10, 3'b110, 1'b0, 1'b0, 1'b0, 4'b0100, 64'hF0, 64'h0F, 64'd0,
                            5'd1, 5'd2, 5'd5, 1'b0, 5'd0, 64'd0, 64'hFF, 64'h0F));
        ops.push_back(mk_op(2'b10, 3'b111, 1'b0, 1'b0, 1'b0, 4'b0100, 64'hF0, 64'h3C, 64'd0,
                            5'd1, 5'd2, 5'd5, 1'b0, 5'd0, 64'd0, 64'h30, 64'h3C));
        ops.push_back(mk_op(2'b11, 3'b101, 1'b1, 1'b0, 1'b1, 4'b0100, 64'h8000_0000_0000_0000,
                            64'd0, 64'd4, 5'd1, 5'd2, 5'd5, 1'b0, 5'd0, 64'd0,
                            64'hF800_0000_0000_0000, 64'd0));
        ops.push_back(mk_op(2'b11, 3'b101, 1'b0, 1'b0, 1'b1, 4'b0100, 64'h8000_0000_0000_0000,
                            64'd0, 64'd4, 5'd1, 5'd2, 5'd5, 1'b0, 5'd0, 64'd0,
                            64'h0800_0000_0000_0000, 64'd0));
        // SRLI by 63: immediate bit 25 set must not be taken as an M op.
        ops.push_back(mk_op(2'b11, 3'b101, 1'b0, 1'b1, 1'b1, 4'b0100, 64'h8000_0000_0000_0000,
                            64'd0, 64'd63, 5'd1, 5'd2, 5'd5, 1'b0, 5'd0, 64'd0, 64'd1, 64'd0));
        // Unsupported M op (funct3 != 000) yields 0 without stalling.
        ops.push_back(mk_op(2'b10, 3'b100, 1'b0, 1'b1, 1'b0, 4'b0100, 64'd6, 64'd3, 64'd0,
                            5'd1, 5'd2, 5'd5, 1'b0, 5'd0, 64'd0, 64'd0, 64'd3));
        ops.push_back(mk_op(2'b00, 3'b011, 1'b0, 1'b0, 1'b1, 4'b1110, 64'h200, 64'd0, 64'h10,
                            5'd1, 5'd2, 5'd5, 1'b0, 5'd0, 64'd0, 64'h210, 64'd0));
        ops.push_back(mk_op(2'b00, 3'b011, 1'b0, 1'b0, 1'b1, 4'b0001, 64'h100, 64'hDEAD, 64'd8,
                            5'd1, 5'd2, 5'd6, 1'b0, 5'd0, 64'd0, 64'h108, 64'hDEAD));
        foreach (ops[i]) begin
            @(negedge clk);
            apply_op(ops[i]);
            sb.push_back(mk_exp(ops[i].ctl, ops[i].rd, ops[i].exp_res, ops[i].exp_sd));
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            n_checks++;
            if (obs_vec !== exp_v) begin
                n_fail++; $display("FAIL alu[%0d]: got %h expected %h", i, obs_vec, exp_v);
            end
        end
    endtask

    task automatic test_back_to_back();
        op_t ops[$];
        ops.push_back(mk_op(2'b10, 3'b000, 1'b0, 1'b0, 1'b0, 4'b0100, 64'd1, 64'd2, 64'd0,
                            5'd1, 5'd2, 5'd3, 1'b0, 5'd0, 64'd0, 64'd3, 64'd2));
        // x4 = x3 + x3, stale ID/EX data; MEM/WB also has x3=9 but EX/MEM wins.
        ops.push_back(mk_op(2'b10, 3'b000, 1'b0, 1'b0, 1'b0, 4'b0100, 64'd0, 64'd0, 64'd0,
                            5'd3, 5'd3, 5'd4, 1'b1, 5'd3, 64'd9, 64'd6, 64'd3));
        // EX/MEM now holds x4, so MEM/WB x3=9 is used.
        ops.push_back(mk_op(2'b10, 3'b000, 1'b0, 1'b0, 1'b0, 4'b0100, 64'd0, 64'd0, 64'd0,
                            5'd3, 5'd3, 5'd6, 1'b1, 5'd3, 64'd9, 64'd18, 64'd9));
        ops.push_back(mk_op(2'b10, 3'b000, 1'b0, 1'b0, 1'b0, 4'b0100, 64'd1, 64'd2, 64'd0,
                            5'd1, 5'd2, 5'd0, 1'b0, 5'd0, 64'd0, 64'd3, 64'd2));
        // x0 never forwards from either stage.
        ops.push_back(mk_op(2'b10, 3'b000, 1'b0, 1'b0, 1'b0, 4'b0100, 64'd10, 64'd20, 64'd0,
                            5'd0, 5'd0, 5'd7, 1'b1, 5'd0, 64'd77, 64'd30, 64'd20));
        // MEM/WB write disabled: no forward; this op writes with RegWrite=0.
        ops.push_back(mk_op(2'b10, 3'b000, 1'b0, 1'b0, 1'b0, 4'b0000, 64'd4, 64'd6, 64'd0,
                            5'd3, 5'd3, 5'd8, 1'b0, 5'd3, 64'd9, 64'd10, 64'd6));
        // EX/MEM rd=8 but RegWrite=0: no forward.
        ops.push_back(mk_op(2'b10, 3'b000, 1'b0, 1'b0, 1'b0, 4'b0100, 64'd1, 64'd1, 64'd0,
                            5'd8, 5'd8, 5'd9, 1'b0, 5'd0, 64'd0, 64'd2, 64'd1));
        foreach (ops[i]) begin
            @(negedge clk);
            apply_op(ops[i]);
            sb.push_back(mk_exp(ops[i].ctl, ops[i].rd, ops[i].exp_res, ops[i].exp_sd));
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            n_checks++;
            if (obs_vec !== exp_v) begin
                n_fail++; $display("FAIL fwd[%0d]: got %h expected %h", i, obs_vec, exp_v);
            end
        end
    endtask

    task automatic test_flush_alu();
        @(negedge clk);
        apply_op(mk_op(2'b10, 3'b000, 1'b0, 1'b0, 1'b0, 4'b0100, 64'd5, 64'd7, 64'd0,
                       5'd1, 5'd2, 5'd3, 1'b0, 5'd0, 64'd0, 64'd12, 64'd7));
        sb.push_back(mk_exp(4'b0100, 5'd3, 64'd12, 64'd7));
        @(posedge clk); #1;
        exp_v = sb.pop_front();
        n_checks++;
        if (obs_vec !== exp_v) begin
            n_fail++; $display("FAIL flush_pre: got %h expected %h", obs_vec, exp_v);
        end
        @(negedge clk);
        apply_op(mk_op(2'b10, 3'b000, 1'b0, 1'b0, 1'b0, 4'b0100, 64'd1, 64'd1, 64'd0,
                       5'd1, 5'd2, 5'd4, 1'b0, 5'd0, 64'd0, 64'd2, 64'd1));
        flush_in = 1'b1;
        sb.push_back(138'd0);
        @(posedge clk); #1;
        exp_v = sb.pop_front();
        n_checks++;
        if (obs_vec !== exp_v) begin
            n_fail++; $display("FAIL flush_bubble: got %h expected %h", obs_vec, exp_v);
        end
        @(negedge clk);
        drive_nop();
    endtask

    task automatic test_mul();
        int n_stall = 0;
        int edges   = 0;
        bit got     = 1'b0;
        @(negedge clk);
        apply_op(mk_op(2'b10, 3'b000, 1'b0, 1'b1, 1'b0, 4'b0100, 64'hFFFF_FFFF_FFFF_FFFF,
                       64'd3, 64'd0, 5'd1, 5'd2, 5'd7, 1'b0, 5'd0, 64'd0, 64'd0, 64'd0));
        sb.push_back(mk_exp(4'b0100, 5'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'd3));
        for (int c = 0; c < 200; c++) begin
            // Late MEM/WB write to x1 must not disturb the latched operand.
            if (c == 10) begin
                memwb_RegWrite_in = 1'b1; memwb_rd_in = 5'd1; memwb_wdata_in = 64'd5;
            end
            #1;
            if (stall_out) n_stall++;
            @(posedge clk); #1;
            if (obs_vec !== 138'd0) begin
                got = 1'b1; edges = c + 1;
                break;
            end
            @(negedge clk);
        end
        exp_v = sb.pop_front();
        n_checks++;
        if (!got || obs_vec !== exp_v) begin
            n_fail++; $display("FAIL mul_result: got %h expected %h", obs_vec, exp_v);
        end
        n_checks++;
        if (edges != 66) begin
            n_fail++; $display("FAIL mul_latency: got %0d edges expected 66", edges);
        end
        n_checks++;
        if (n_stall != 65) begin
            n_fail++; $display("FAIL mul_stall_cycles: got %0d expected 65", n_stall);
        end
        @(negedge clk);
        drive_nop();
    endtask

    task automatic test_flush_mul();
        int n_stall = 0;
        @(negedge clk);
        apply_op(mk_op(2'b10, 3'b000, 1'b0, 1'b1, 1'b0, 4'b0100, 64'd5, 64'd7, 64'd0,
                       5'd1, 5'd2, 5'd9, 1'b0, 5'd0, 64'd0, 64'd0, 64'd0));
        for (int c = 0; c < 40; c++) begin
            if (c == 21) begin
                // Cycle 21 is BUSY with count 20.
                flush_in = 1'b1;
                #1;
                n_checks++;
                if (stall_out !== 1'b0) begin
                    n_fail++; $display("FAIL flush_stall_drop: got %b expected 0", stall_out);
                end
                break;
            end
            #1;
            if (stall_out) n_stall++;
            @(posedge clk);
            @(negedge clk);
        end
        n_checks++;
        if (n_stall != 21) begin
            n_fail++; $display("FAIL flush_pre_stall: got %0d expected 21", n_stall);
        end
        sb.push_back(138'd0);
        @(posedge clk); #1;
        exp_v = sb.pop_front();
        n_checks++;
        if (obs_vec !== exp_v) begin
            n_fail++; $display("FAIL flush_mul_bubble: got %h expected %h", obs_vec, exp_v);
        end
        // FSM must be IDLE: a plain ADD goes through without stalling.
        @(negedge clk);
        flush_in = 1'b0;
        apply_op(mk_op(2'b10, 3'b000, 1'b0, 1'b0, 1'b0, 4'b0100, 64'd2, 64'd3, 64'd0,
                       5'd1, 5'd2, 5'd10, 1'b0, 5'd0, 64'd0, 64'd5, 64'd3));
        sb.push_back(mk_exp(4'b0100, 5'd10, 64'd5, 64'd3));
        #1;
        n_checks++;
        if (stall_out !== 1'b0) begin
            n_fail++; $display("FAIL flush_idle_stall: got %b expected 0", stall_out);
        end
        @(posedge clk); #1;
        exp_v = sb.pop_front();
        n_checks++;
        if (obs_vec !== exp_v) begin
            n_fail++; $display("FAIL flush_after_add: got %h expected %h", obs_vec, exp_v);
        end
    endtask

    task automatic test_rst_mid_mul();
        @(negedge clk);
        apply_op(mk_op(2'b10, 3'b000, 1'b0, 1'b1, 1'b0, 4'b0100, 64'd2, 64'd3, 64'd0,
                       5'd1, 5'd2, 5'd11, 1'b0, 5'd0, 64'd0, 64'd0, 64'd0));
        repeat (10) @(negedge clk);
        #1;
        n_checks++;
        if (stall_out !== 1'b1) begin
            n_fail++; $display("FAIL rst_pre_busy: got %b expected 1", stall_out);
        end
        #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({obs_vec, stall_out} !== 139'd0) begin
            n_fail++; $display("FAIL rst_mid_outputs: got %h expected 0", {obs_vec, stall_out});
        end
        @(negedge clk);
        rst = 1'b0;
        apply_op(mk_op(2'b10, 3'b000, 1'b0, 1'b0, 1'b0, 4'b0100, 64'd4, 64'd4, 64'd0,
                       5'd1, 5'd2, 5'd12, 1'b0, 5'd0, 64'd0, 64'd8, 64'd4));
        sb.push_back(mk_exp(4'b0100, 5'd12, 64'd8, 64'd4));
        #1;
        n_checks++;
        if (stall_out !== 1'b0) begin
            n_fail++; $display("FAIL rst_after_stall: got %b expected 0", stall_out);
        end
        @(posedge clk); #1;
        exp_v = sb.pop_front();
        n_checks++;
        if (obs_vec !== exp_v) begin
            n_fail++; $display("FAIL rst_after_add: got %h expected %h", obs_vec, exp_v);
        end
        @(negedge clk);
        drive_nop();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu();
        test_back_to_back();
        test_flush_alu();
        test_mul();
        test_flush_mul();
        test_rst_mid_mul();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
